// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer for the 8x16 register-file/ALU datapath.
// Decodes ALU/LDI/REP/NOP words and issues per-cycle datapath controls.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        busy,
    output logic        done,
    output logic        carry_flag,
    input  logic        alu_cout,
    output logic        alu_sel,
    output logic        alu_wr,
    output logic [2:0]  alu_op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic [15:0] d_in
);

    typedef enum logic [1:0] {IDLE, EXEC, FLAG} state_t;
    typedef enum logic [1:0] {
        CLS_ALU = 2'b00,
        CLS_LDI = 2'b01,
        CLS_REP = 2'b10,
        CLS_NOP = 2'b11
    } cls_t;

    state_t      state, state_nxt;
    logic [15:0] ir;
    logic [2:0]  rep_cnt;
    cls_t        cls;
    logic        accept;

    assign cls    = cls_t'(ir[15:14]);
    assign accept = instr_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ir         <= '0;
            rep_cnt    <= '0;
            carry_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ir      <= instr;
                rep_cnt <= (instr[15:14] == CLS_REP) ? instr[4:2] : '0;
            end else if (state == EXEC && rep_cnt != '0) begin
                rep_cnt <= rep_cnt - 3'd1;
            end
            // alu_cout is registered in the datapath, so in FLAG it holds the last EXEC carry
            if (state == FLAG && (cls == CLS_ALU || cls == CLS_REP))
                carry_flag <= alu_cout;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = (state == IDLE);
        busy        = (state != IDLE);
        done        = 1'b0;
        alu_sel     = 1'b0;
        alu_wr      = 1'b0;
        alu_op      = '0;
        rd_addr_a   = '0;
        rd_addr_b   = '0;
        wr_addr     = '0;
        d_in        = '0;
        case (state)
            IDLE: begin
                if (instr_valid)
                    state_nxt = (instr[15:14] == CLS_NOP) ? FLAG : EXEC;
            end
            EXEC: begin
                state_nxt = FLAG;
                case (cls)
                    CLS_ALU: begin
                        alu_sel   = 1'b1;
                        alu_wr    = 1'b1;
                        alu_op    = ir[13:11];
                        rd_addr_a = ir[7:5];
                        rd_addr_b = ir[4:2];
                        wr_addr   = ir[10:8];
                    end
                    CLS_LDI: begin
                        alu_wr  = 1'b1;
                        wr_addr = ir[13:11];
                        d_in    = {5'b0, ir[10:0]};
                    end
                    CLS_REP: begin
                        alu_sel   = 1'b1;
                        alu_wr    = 1'b1;
                        alu_op    = ir[13:11];
                        rd_addr_a = ir[10:8];
                        rd_addr_b = ir[7:5];
                        wr_addr   = ir[10:8];
                        if (rep_cnt != '0)
                            state_nxt = EXEC;
                    end
                    default: ;
                endcase
            end
            FLAG: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: per-cycle expected controls are queued
// when an instruction is issued and compared on each falling edge.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, instr_valid, alu_cout;
    logic [15:0] instr;
    logic        instr_ready, busy, done, carry_flag, alu_sel, alu_wr;
    logic [2:0]  alu_op, rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0] d_in;

    alu_seq_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .busy(busy), .done(done), .carry_flag(carry_flag),
        .alu_cout(alu_cout), .alu_sel(alu_sel), .alu_wr(alu_wr), .alu_op(alu_op),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .d_in(d_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready, busy, done, carry, sel, wr;
        logic [2:0]  op, ra, rb, wa;
        logic [15:0] din;
    } obs_t;

    obs_t        sb[$];
    obs_t        e, a;
    logic        model_carry;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] rf [8];

    // Immediate-load half of the datapath, enough to observe LDI write-back.
    always @(posedge clk)
        if (!reset && alu_wr && !alu_sel && wr_addr != 3'd0) rf[wr_addr] <= d_in;

    function automatic obs_t snap();
        obs_t o;
        o.ready = instr_ready; o.busy = busy; o.done = done; o.carry = carry_flag;
        o.sel = alu_sel; o.wr = alu_wr; o.op = alu_op; o.ra = rd_addr_a;
        o.rb = rd_addr_b; o.wa = wr_addr; o.din = d_in;
        return o;
    endfunction

    function automatic obs_t idle_rec(input logic c);
        obs_t o = '0;
        o.ready = 1'b1;
        o.carry = c;
        return o;
    endfunction

    // Build the expected cycle sequence from the instruction encoding, then present it.
    task automatic issue(input logic [15:0] ins, input logic cout);
        obs_t o;
        int unsigned n;
        o = '0;
        o.busy = 1'b1; o.carry = model_carry; o.wr = 1'b1;
        case (ins[15:14])
            2'b00: begin
                o.sel = 1'b1; o.op = ins[13:11]; o.ra = ins[7:5]; o.rb = ins[4:2]; o.wa = ins[10:8];
                sb.push_back(o);
            end
            2'b01: begin
                o.wa = ins[13:11]; o.din = {5'b0, ins[10:0]};
                sb.push_back(o);
            end
            2'b10: begin
                o.sel = 1'b1; o.op = ins[13:11]; o.ra = ins[10:8]; o.rb = ins[7:5]; o.wa = ins[10:8];
                n = ins[4:2] + 1;
                for (int unsigned i = 0; i < n; i++) sb.push_back(o);
            end
            default: ;
        endcase
        o = '0;
        o.busy = 1'b1; o.done = 1'b1; o.carry = model_carry;
        sb.push_back(o);
        if (ins[15:14] == 2'b00 || ins[15:14] == 2'b10) model_carry = cout;
        sb.push_back(idle_rec(model_carry));
        instr_valid = 1'b1;
        instr = ins;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b0; instr = '0; alu_cout = 1'b0; model_carry = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) sb.push_back(idle_rec(1'b0));
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); a = snap(); checks++;
            if (a !== e) begin errors++; $display("FAIL reset_idle got %h exp %h", a, e); end
        end
    endtask

    task automatic test_ldi();
        int cyc = 0;
        issue(16'h5DA5, 1'b1);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); a = snap(); checks++;
            if (a !== e) begin errors++; $display("FAIL ldi cyc%0d got %h exp %h", cyc, a, e); end
            alu_cout = 1'b1; instr_valid = 1'b0; cyc++;
        end
        checks++;
        if (rf[3] !== 16'h05A5) begin errors++; $display("FAIL ldi_r3 got %h exp 05a5", rf[3]); end
    endtask

    task automatic test_alu();
        int cyc = 0;
        issue(16'h1528, 1'b1);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); a = snap(); checks++;
            if (a !== e) begin errors++; $display("FAIL alu cyc%0d got %h exp %h", cyc, a, e); end
            alu_cout = e.done; instr_valid = 1'b0; cyc++;
        end
    endtask

    task automatic test_nop();
        int cyc = 0;
        issue(16'hC000, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); a = snap(); checks++;
            if (a !== e) begin errors++; $display("FAIL nop cyc%0d got %h exp %h", cyc, a, e); end
            alu_cout = 1'b0; instr_valid = 1'b0; cyc++;
        end
    endtask

    task automatic test_rep();
        int cyc = 0;
        issue(16'h9E2C, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); a = snap(); checks++;
            if (a !== e) begin errors++; $display("FAIL rep cyc%0d got %h exp %h", cyc, a, e); end
            alu_cout = !e.done;
            // keep a different word pending while busy; it must not be taken
            if (sb.size() != 0) instr = 16'h5FFF; else instr_valid = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog [3];
        logic        cy   [3];
        int cyc = 0;
        prog[0] = 16'h38EC; cy[0] = 1'b1;
        prog[1] = 16'hA8E0; cy[1] = 1'b1;
        prog[2] = 16'h7FFF; cy[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            issue(prog[k], cy[k]);
            while (sb.size() != 0) begin
                @(negedge clk);
                e = sb.pop_front(); a = snap(); checks++;
                if (a !== e) begin errors++; $display("FAIL b2b i%0d cyc%0d got %h exp %h", k, cyc, a, e); end
                alu_cout = e.done ? cy[k] : !cy[k];
                instr_valid = 1'b0; cyc++;
            end
        end
        checks++;
        if (rf[7] !== 16'h07FF) begin errors++; $display("FAIL ldi_r7 got %h exp 07ff", rf[7]); end
    endtask

    task automatic test_reset_mid_rep();
        int cyc = 0;
        issue(16'h8C5C, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = sb.pop_front(); a = snap(); checks++;
            if (a !== e) begin errors++; $display("FAIL rstmid exec%0d got %h exp %h", i, a, e); end
            alu_cout = 1'b1; instr_valid = 1'b0;
        end
        // reset on the 3rd EXEC cycle, with a NOP offered in the same cycle
        reset = 1'b1; instr_valid = 1'b1; instr = 16'hC000;
        sb.delete();
        model_carry = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back(idle_rec(1'b0));
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); a = snap(); checks++;
            if (a !== e) begin errors++; $display("FAIL rstmid_after cyc%0d got %h exp %h", cyc, a, e); end
            reset = 1'b0; instr_valid = 1'b0; cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu();
        test_nop();
        test_rep();
        test_back_to_back();
        test_reset_mid_rep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Instruction sequencer that drives the 16-bit register-file/ALU datapath (8x16 register file, r0 hardwired zero, 3-bit ALU op, registered carry-out).
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them.
- Issues the datapath controls (sel, wr, op, read/write addresses, d_in) cycle by cycle, including multi-cycle repeat operations.
- Captures the final carry into an architectural flag.

Parameters:
- None. Widths are fixed: 16-bit data/instruction, 3-bit register address, 3-bit ALU op.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; also fans out to the datapath
- instr_valid  input  1  instruction word present
- instr  input  16  instruction word
- instr_ready  output  1  controller can accept an instruction
- busy  output  1  instruction in progress (not IDLE)
- done  output  1  one-cycle pulse when an instruction retires
- carry_flag  output  1  carry of the last retired ALU/REP instruction
- alu_cout  input  1  registered carry-out from datapath
- alu_sel  output  1  datapath write mux: 0 = d_in, 1 = ALU result
- alu_wr  output  1  register-file write enable
- alu_op  output  3  ALU operation
- rd_addr_a  output  3  read port A address
- rd_addr_b  output  3  read port B address
- wr_addr  output  3  write address
- d_in  output  16  immediate data to datapath

Behaviour:
- Instruction classes are set by instr[15:14]:
  - 00 ALU: op = [13:11], rd = [10:8], ra = [7:5], rb = [4:2], [1:0] ignored.
  - 01 LDI: rd = [13:11], imm = [10:0], zero-extended to 16 bits.
  - 10 REP: op = [13:11], rd = [10:8], rb = [7:5], cnt = [4:2]. Performs rd <- rd op rb (cnt+1) times, i.e. 1..8 iterations.
  - 11 NOP.
- FSM states are IDLE, EXEC, FLAG. Control decode is combinational from state and the latched instruction register (IR).
- IDLE:
  - instr_ready = 1, busy = 0.
  - When instr_valid && instr_ready at an edge: IR <- instr; rep_cnt <- instr[4:2] for REP, otherwise 0.
  - Next state is EXEC for ALU/LDI/REP, and FLAG for NOP.
- EXEC, ALU: alu_sel = 1, alu_wr = 1, alu_op = op, rd_addr_a = ra, rd_addr_b = rb, wr_addr = rd. Lasts 1 cycle, then FLAG.
- EXEC, LDI: alu_sel = 0, alu_wr = 1, d_in = {5'b0, imm}, wr_addr = rd, alu_op = 0, read addresses = 0. Lasts 1 cycle, then FLAG.
- EXEC, REP: alu_sel = 1, alu_wr = 1, alu_op = op, rd_addr_a = rd, rd_addr_b = rb, wr_addr = rd.
  - Each EXEC cycle with rep_cnt != 0 decrements rep_cnt and stays in EXEC.
  - When rep_cnt == 0, go to FLAG.
  - The EXEC cycle count is exactly cnt+1. The register file reads combinationally, so back-to-back iterations see the updated rd.
- FLAG:
  - done = 1 for exactly one cycle.
  - carry_flag <- alu_cout for ALU/REP. This is the carry of the last EXEC cycle.
  - carry_flag is unchanged for LDI/NOP.
  - Next state is IDLE.
- Outside EXEC, all datapath control outputs are 0 (alu_wr = 0 guaranteed).
- busy = (state != IDLE). instr_ready = (state == IDLE). instr_valid is ignored while busy; there is no buffering.
- Latency from the accept edge:
  - ALU/LDI: done in the 2nd cycle after accept, ready again in the 3rd.
  - REP: done after cnt+2 cycles.
  - NOP: done in the next cycle.
- rd = 0 is issued normally; the datapath discards writes to r0. This is not an error.
- Reset:
  - Forces state to IDLE, clears IR, rep_cnt and carry_flag.
  - done = 0, alu_wr = 0 from the reset edge on.
  - After the reset edge: instr_ready = 1, busy = 0, all control outputs 0.
  - Reset mid-EXEC aborts immediately. No further writes occur and no done is produced.
- An instruction presented in the same cycle reset is high is not accepted.

Test Plan:
- Reset, then idle → instr_ready = 1, busy = 0, carry_flag = 0, all control outputs 0 for 5 cycles.
- LDI r3, 0x5A5 (instr = 16'h5DA5) → in the EXEC cycle: alu_sel = 0, alu_wr = 1, wr_addr = 3, d_in = 16'h05A5. done 2 cycles after accept. With the datapath attached, r3 reads back 16'h05A5.
- ALU op = 3'b010, rd = 5, ra = 1, rb = 2 (instr = 16'h1528) → one EXEC cycle with alu_op = 2, rd_addr_a = 1, rd_addr_b = 2, wr_addr = 5, alu_sel = 1, alu_wr = 1. alu_cout forced to 1 in the FLAG cycle → carry_flag = 1 after done.
- REP with cnt = 3 → exactly 4 consecutive alu_wr = 1 cycles with rd_addr_a = wr_addr = rd. done on the 5th cycle after accept. instr_valid held high throughout is not accepted until instr_ready returns.
- NOP (instr = 16'hC000) → done the cycle after accept, alu_wr never asserted, carry_flag unchanged (preload to 1 via a prior ALU instruction and verify it stays 1).
- REP with cnt = 7, reset asserted on the 3rd EXEC cycle → alu_wr = 0 from the next cycle, no done pulse, carry_flag = 0, instr_ready = 1 after the reset edge.
